// File: rtl/norm_32_seq.sv
// norm_32_seq: sequential left-normalizer for a 32-bit mantissa.
// A 5-step binary search (shift by 16, 8, 4, 2, 1) runs one step per clock, so the
// latency is fixed. Define NORM_EXP_CLAMP_EN to stop shifting when the exponent
// would go below zero; the result is then denormal instead of wrapped.
module norm_32_seq #(
  parameter int unsigned EXP_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_mant,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [4:0]       out_cnt,
  output logic             out_zero,
  output logic             out_uflow
);

`ifdef NORM_EXP_CLAMP_EN
  localparam bit Clamp = 1'b1;
`else
  localparam bit Clamp = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      mant_q, mant_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             uflow_q, uflow_d;
  logic [2:0]       k_q, k_d;

  logic [4:0]       step;
  logic [EXP_W:0]   diff;
  logic             borrow;
  logic             top_zero;
  logic             do_shift;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
      k_q     <= k_d;
    end
  end

  // Step decode: shift amount and whether the top 2^k mantissa bits are clear.
  always_comb begin
    step     = 5'd1 << k_q;
    // Extra MSB of diff holds the borrow; no borrow means exp_q >= step.
    diff     = {1'b0, exp_q} - (EXP_W + 1)'(step);
    borrow   = diff[EXP_W];
    top_zero = 1'b0;
    case (k_q)
      3'd4:    top_zero = (mant_q[31:16] == '0);
      3'd3:    top_zero = (mant_q[31:24] == '0);
      3'd2:    top_zero = (mant_q[31:28] == '0);
      3'd1:    top_zero = (mant_q[31:30] == '0);
      default: top_zero = !mant_q[31];
    endcase
    do_shift = top_zero && !zero_q && (!Clamp || !borrow);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    uflow_d = uflow_q;
    k_d     = k_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          mant_d  = in_mant;
          zero_d  = (in_mant == '0);
          exp_d   = (in_mant == '0) ? '0 : in_exp;
          cnt_d   = '0;
          uflow_d = 1'b0;
          k_d     = 3'd4;
          state_d = StShift;
        end
      end
      StShift: begin
        if (do_shift) begin
          mant_d  = mant_q << step;
          cnt_d   = cnt_q + step;
          exp_d   = diff[EXP_W-1:0];
          // Total shift < 2^EXP_W, so at most one borrow ever occurs.
          uflow_d = uflow_q | (borrow & !Clamp);
        end
        if (k_q == 3'd0) begin
          state_d = StDone;
        end else begin
          k_d = k_q - 3'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_mant  = mant_q;
    out_exp   = exp_q;
    out_cnt   = cnt_q;
    out_zero  = zero_q;
    out_uflow = uflow_q;
  end

endmodule
